mm_cache_mp: RTL and testbench
==============================

Name: mm_cache_mp

Overview:
Parametrised successor of the shared main-memory-side block cache. It is direct-mapped and write-back, serving NUM_PORTS lower-level caches (ICache/DCache channels) through one round-robin arbiter. Only dirty victims are written to main memory. Full-block writes allocate without a fill read. It sits between the per-core L1 caches and the main-memory controller.

Parameters:
NUM_PORTS, 2, number of lower-level requester channels (>=1)
SETS, 16, number of direct-mapped lines (power of 2, >=2)
BLOCK_BITS, 512, line size in bits (power of 2, >=64)
ADDR_BITS, 32, byte address width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  NUM_PORTS  per-port request strobe, held until accepted
req_we_i  in  NUM_PORTS  1=full-block write, 0=block read
req_addr_i  in  NUM_PORTS*ADDR_BITS  per-port byte address (offset bits ignored)
req_wdata_i  in  NUM_PORTS*BLOCK_BITS  per-port write block
req_ready_o  out  NUM_PORTS  one-hot accept pulse for the granted port
resp_valid_o  out  NUM_PORTS  one-hot one-cycle completion pulse
resp_addr_o  out  ADDR_BITS  block-aligned address of the completed request
resp_rdata_o  out  BLOCK_BITS  read data, valid with resp_valid_o
mem_req_o  out  1  main-memory request, held until mem_ack_i
mem_we_o  out  1  1=writeback, 0=fill read
mem_addr_o  out  ADDR_BITS  block-aligned memory address
mem_wdata_o  out  BLOCK_BITS  victim block for writeback
mem_ack_i  in  1  memory completion, one cycle
mem_rdata_i  in  BLOCK_BITS  fill data, valid with mem_ack_i

Behaviour:
- Address split: OFF=log2(BLOCK_BITS/8); IDX=addr[OFF+log2(SETS)-1:OFF]; TAG=addr[ADDR_BITS-1:OFF+log2(SETS)].
- Per-line storage: data, tag, valid, dirty. Reset clears valid and dirty; data and tag are not reset.
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer = port 0.
- Reset asserted mid-transaction aborts it immediately: mem_req_o drops, no response is issued, no state is retained.
- Arbiter: round-robin among req_valid_i. The last granted port has lowest priority next time. Grant is sampled only in IDLE.
- FSM states:
  - IDLE: if any valid request, latch port, we, addr, wdata; pulse req_ready_o[port]; go to LOOKUP.
  - LOOKUP: hit = valid & tag match.
    - Read hit -> RESP.
    - Write hit -> overwrite data, set dirty -> RESP.
    - Miss with valid & dirty victim -> WB.
    - Miss otherwise: read -> FILL; write -> install data, tag, valid=1, dirty=1 -> RESP.
  - WB: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, IDX, 0}, mem_wdata_o=victim data. On mem_ack_i: clear dirty; read -> FILL; write -> install as above -> RESP.
  - FILL: mem_req_o=1, mem_we_o=0, mem_addr_o=block-aligned request addr. On mem_ack_i: install mem_rdata_i, valid=1, dirty=0 -> RESP.
  - RESP: resp_valid_o[port]=1 for one cycle; resp_addr_o = aligned addr; resp_rdata_o = line data (reads; 0 for writes) -> IDLE.
- Latency (cycles from req_ready_o to resp_valid_o):
  - Hit: 2.
  - Clean miss: 3 + memory latency.
  - Dirty miss: adds one writeback round trip.
- mem_req_o, mem_we_o and mem_addr_o stay stable until mem_ack_i. mem_ack_i outside WB/FILL is ignored.
- Simultaneous requests from all ports: served strictly one at a time in rotation. A port is never starved beyond NUM_PORTS-1 grants.
- The same port may re-request in the cycle after its resp_valid_o pulse; it is then granted per rotation.
- Requests hold req_valid_i until req_ready_o. Deasserting early is a protocol violation and is not checked.

Optional Feature:
MM_CACHE_PERF_EN:
- Defined: adds outputs perf_hits_o, perf_misses_o and perf_wbs_o (32-bit each, saturating).
  - perf_hits_o increments in LOOKUP on hit.
  - perf_misses_o increments in LOOKUP on miss.
  - perf_wbs_o increments on WB ack.
  - All clear on reset.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package mm_cache_pkg: state enum (IDLE, LOOKUP, WB, FILL, RESP); helper functions for offset, index and tag widths.
- Sub-module rr_arbiter (NUM_PORTS): request vector in, one-hot grant out, pointer update on an accept strobe.

Test Plan:
1. Reset, then port0 reads 0x0000_0040 -> FILL with mem_addr_o=0x40, mem_we_o=0; ack with data D -> resp_valid_o=01, resp_rdata_o=D. Repeat the read -> hit, response 2 cycles after accept, no mem_req_o.
2. Port1 writes block W to 0x40, then reads 0x40 -> no memory traffic; read returns W.
3. Dirty line at 0x40 (SETS=16, so 0x440 maps to the same index); port0 reads 0x440 -> writeback of W to 0x40 first, then fill read of 0x440; the response carries the fill data.
4. Both ports hold req_valid_i continuously -> grants alternate 0,1,0,1; no port receives two consecutive grants.
5. Write miss to a clean/invalid index, e.g. 0x80 -> no fill read issued; a later read of 0x80 returns the written data.
6. rst_n_i asserted during FILL -> all outputs 0 immediately; after release, a read of the prior address misses.

Source files
------------

// File: rtl/mm_cache_pkg.sv
// Shared types and address-split helpers for the main-memory-side block cache.
// Widths are derived from the cache geometry parameters.
package mm_cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WB,
      ST_FILL,
      ST_RESP
   } state_e;

   function automatic int off_bits(input int block_bits);
      return $clog2(block_bits / 8);
   endfunction

   function automatic int idx_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int addr_bits, input int block_bits, input int sets);
      return addr_bits - off_bits(block_bits) - idx_bits(sets);
   endfunction

   // A single port still needs a 1-bit index so the port register has a width.
   function automatic int port_bits(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage

// File: rtl/mm_cache_mp_if.sv
// Requester and main-memory handshake bundle of mm_cache_mp.
// slave = cache view, master = environment (L1 channels plus memory controller).
interface mm_cache_mp_if #(
   parameter int NUM_PORTS  = 2,
   parameter int BLOCK_BITS = 512,
   parameter int ADDR_BITS  = 32
);
   logic [NUM_PORTS-1:0]            req_valid_i;
   logic [NUM_PORTS-1:0]            req_we_i;
   logic [NUM_PORTS*ADDR_BITS-1:0]  req_addr_i;
   logic [NUM_PORTS*BLOCK_BITS-1:0] req_wdata_i;
   logic [NUM_PORTS-1:0]            req_ready_o;
   logic [NUM_PORTS-1:0]            resp_valid_o;
   logic [ADDR_BITS-1:0]            resp_addr_o;
   logic [BLOCK_BITS-1:0]           resp_rdata_o;
   logic                            mem_req_o;
   logic                            mem_we_o;
   logic [ADDR_BITS-1:0]            mem_addr_o;
   logic [BLOCK_BITS-1:0]           mem_wdata_o;
   logic                            mem_ack_i;
   logic [BLOCK_BITS-1:0]           mem_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_ack_i, mem_rdata_i,
      output req_ready_o, resp_valid_o, resp_addr_o, resp_rdata_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_ack_i, mem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_addr_o, resp_rdata_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mm_cache_mp_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the
// winner on accept so the last granted port has lowest priority next time.
import mm_cache_pkg::*;

module rr_arbiter #(
   parameter int NUM_PORTS = 2,
   localparam int PW = port_bits(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 accept,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [PW-1:0]        gnt_idx
);

   logic [PW-1:0] ptr_q;
   logic          found;
   int            p;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      p       = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         p = (int'(ptr_q) + i) % NUM_PORTS;
         if (!found && req[p]) begin
            found   = 1'b1;
            gnt[p]  = 1'b1;
            gnt_idx = PW'(p);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mm_cache_mp.sv
// Direct-mapped write-back block cache shared by NUM_PORTS L1 channels.
// Optional perf counters are enabled with MM_CACHE_PERF_EN.
import mm_cache_pkg::*;

module mm_cache_mp #(
   parameter int NUM_PORTS  = 2,
   parameter int SETS       = 16,
   parameter int BLOCK_BITS = 512,
   parameter int ADDR_BITS  = 32
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   mm_cache_mp_if.slave   bus
`ifdef MM_CACHE_PERF_EN
   ,
   output logic [31:0]    perf_hits_o,
   output logic [31:0]    perf_misses_o,
   output logic [31:0]    perf_wbs_o
`endif
);

   localparam int OFF = off_bits(BLOCK_BITS);
   localparam int IB  = idx_bits(SETS);
   localparam int TB  = tag_bits(ADDR_BITS, BLOCK_BITS, SETS);
   localparam int PW  = port_bits(NUM_PORTS);
   localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((64'd1 << OFF) - 64'd1);

   state_e                state_q, state_d;
   logic [PW-1:0]         port_q;
   logic                  we_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [BLOCK_BITS-1:0] wdata_q;

   logic [BLOCK_BITS-1:0] data_mem [SETS];
   logic [TB-1:0]         tag_mem  [SETS];
   logic [SETS-1:0]       valid_q, dirty_q;

   logic [NUM_PORTS-1:0]  gnt;
   logic [PW-1:0]         gnt_idx;
   logic                  accept, hit, install_wr, install_fill, clr_dirty;
   logic [IB-1:0]         idx;
   logic [TB-1:0]         tag;
   logic [ADDR_BITS-1:0]  addr_al;

   assign idx     = addr_q[OFF+IB-1:OFF];
   assign tag     = addr_q[ADDR_BITS-1:OFF+IB];
   assign addr_al = addr_q & ~OFF_MASK;
   assign hit     = valid_q[idx] && (tag_mem[idx] == tag);

   rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .req     (bus.req_valid_i),
      .accept  (accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         port_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            port_q  <= gnt_idx;
            we_q    <= bus.req_we_i[gnt_idx];
            addr_q  <= bus.req_addr_i[int'(gnt_idx)*ADDR_BITS +: ADDR_BITS];
            wdata_q <= bus.req_wdata_i[int'(gnt_idx)*BLOCK_BITS +: BLOCK_BITS];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      install_wr   = 1'b0;
      install_fill = 1'b0;
      clr_dirty    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req_valid_i) begin
               accept  = 1'b1;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (hit) begin
               install_wr = we_q;
               state_d    = ST_RESP;
            end else if (valid_q[idx] && dirty_q[idx]) begin
               state_d = ST_WB;
            end else if (we_q) begin
               // Full-block write: nothing to merge, so no fill read is needed.
               install_wr = 1'b1;
               state_d    = ST_RESP;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_WB: begin
            if (bus.mem_ack_i) begin
               clr_dirty  = 1'b1;
               install_wr = we_q;
               state_d    = we_q ? ST_RESP : ST_FILL;
            end
         end
         ST_FILL: begin
            if (bus.mem_ack_i) begin
               install_fill = 1'b1;
               state_d      = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Line payload is deliberately left unreset; valid bits gate its use.
   always_ff @(posedge clk_i) begin
      if (install_wr) begin
         data_mem[idx] <= wdata_q;
         tag_mem[idx]  <= tag;
      end else if (install_fill) begin
         data_mem[idx] <= bus.mem_rdata_i;
         tag_mem[idx]  <= tag;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (install_wr) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b1;
      end else if (install_fill) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (clr_dirty) begin
         dirty_q[idx] <= 1'b0;
      end
   end

   // Outputs decode straight from state so an async reset zeroes them at once.
   assign bus.req_ready_o  = accept ? gnt : '0;
   assign bus.resp_valid_o = (state_q == ST_RESP) ? (NUM_PORTS'(1) << port_q) : '0;
   assign bus.resp_addr_o  = (state_q == ST_RESP) ? addr_al : '0;
   assign bus.resp_rdata_o = (state_q == ST_RESP && !we_q) ? data_mem[idx] : '0;
   assign bus.mem_req_o    = (state_q == ST_WB) || (state_q == ST_FILL);
   assign bus.mem_we_o     = (state_q == ST_WB);
   assign bus.mem_addr_o   = (state_q == ST_WB)   ? {tag_mem[idx], idx, {OFF{1'b0}}} :
                             (state_q == ST_FILL) ? addr_al : '0;
   assign bus.mem_wdata_o  = (state_q == ST_WB) ? data_mem[idx] : '0;

`ifdef MM_CACHE_PERF_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         perf_hits_o   <= '0;
         perf_misses_o <= '0;
         perf_wbs_o    <= '0;
      end else begin
         if (state_q == ST_LOOKUP && hit && perf_hits_o != '1)
            perf_hits_o <= perf_hits_o + 1'b1;
         if (state_q == ST_LOOKUP && !hit && perf_misses_o != '1)
            perf_misses_o <= perf_misses_o + 1'b1;
         if (state_q == ST_WB && bus.mem_ack_i && perf_wbs_o != '1)
            perf_wbs_o <= perf_wbs_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mm_cache_mp.sv
// Self-checking bench for mm_cache_mp: scoreboard of expected responses plus a
// latency-configurable main-memory responder with its own backing store.
module tb_mm_cache_mp;

   localparam int NP  = 2;
   localparam int SETS = 16;
   localparam int BB  = 512;
   localparam int AB  = 32;
   localparam int MEM_LAT = 3;

   typedef struct {
      int            port;
      logic [AB-1:0] addr;
      logic [BB-1:0] rdata;
      bit            chk_lat;
      int            acc_cyc;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AB-1:0] addr;
      logic [BB-1:0] wdata;
   } mem_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mem_en = 1'b1;
   int   mem_req_cycles = 0;

   exp_t exp_q[$];
   mem_t mem_log[$];
   int   gnt_log[$];
   logic [BB-1:0] mem_model [logic [AB-1:0]];
   logic [BB-1:0] golden    [logic [AB-1:0]];

   mm_cache_mp_if #(.NUM_PORTS(NP), .BLOCK_BITS(BB), .ADDR_BITS(AB)) bus ();

   mm_cache_mp #(.NUM_PORTS(NP), .SETS(SETS), .BLOCK_BITS(BB), .ADDR_BITS(AB)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [BB-1:0] pattern(input logic [AB-1:0] a);
      return {16{a ^ 32'h5A5A_0000}};
   endfunction

   function automatic logic [BB-1:0] rand_block();
      logic [BB-1:0] b;
      for (int i = 0; i < BB / 32; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   function automatic void push_exp(input int port, input bit we, input logic [AB-1:0] addr,
                                    input logic [BB-1:0] wdata, input bit chk_lat);
      exp_t e;
      logic [AB-1:0] al;
      al = addr & ~32'h3F;
      e.port    = port;
      e.addr    = al;
      e.chk_lat = chk_lat;
      e.acc_cyc = cyc;
      if (we) begin
         golden[al] = wdata;
         e.rdata    = '0;
      end else begin
         e.rdata = golden.exists(al) ? golden[al] : pattern(al);
      end
      exp_q.push_back(e);
   endfunction

   // Main-memory responder: acks MEM_LAT cycles after seeing a request.
   initial begin
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_en && rst_n && bus.mem_req_o) begin
            repeat (MEM_LAT - 1) begin @(posedge clk); #1; end
            if (mem_en && rst_n && bus.mem_req_o) begin
               mem_log.push_back('{we: bus.mem_we_o, addr: bus.mem_addr_o, wdata: bus.mem_wdata_o});
               if (bus.mem_we_o)
                  mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
               else
                  bus.mem_rdata_i = mem_model.exists(bus.mem_addr_o) ?
                                    mem_model[bus.mem_addr_o] : pattern(bus.mem_addr_o);
               bus.mem_ack_i = 1'b1;
               @(posedge clk); #1;
               bus.mem_ack_i   = 1'b0;
               bus.mem_rdata_i = '0;
            end
         end
      end
   end

   // Response scoreboard and grant / memory-activity monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.mem_req_o) mem_req_cycles++;
         if (rst_n && |bus.req_ready_o) gnt_log.push_back(bus.req_ready_o[1] ? 1 : 0);
         if (rst_n && |bus.resp_valid_o) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_resp: resp_valid=%b with empty scoreboard", bus.resp_valid_o);
            end else begin
               e = exp_q.pop_front();
               n_cmp++;
               if (bus.resp_valid_o !== (NP'(1) << e.port)) begin
                  n_err++;
                  $display("FAIL resp_port: got %b want %b", bus.resp_valid_o, NP'(1) << e.port);
               end
               n_cmp++;
               if (bus.resp_addr_o !== e.addr) begin
                  n_err++;
                  $display("FAIL resp_addr: got %h want %h", bus.resp_addr_o, e.addr);
               end
               n_cmp++;
               if (bus.resp_rdata_o !== e.rdata) begin
                  n_err++;
                  $display("FAIL resp_rdata @%h: got %h want %h", e.addr,
                           bus.resp_rdata_o[63:0], e.rdata[63:0]);
               end
               if (e.chk_lat) begin
                  n_cmp++;
                  if (cyc - e.acc_cyc !== 2) begin
                     n_err++;
                     $display("FAIL hit_latency @%h: got %0d want 2", e.addr, cyc - e.acc_cyc);
                  end
               end
            end
         end
      end
   end

   task automatic do_req(input int port, input bit we, input logic [AB-1:0] addr,
                         input logic [BB-1:0] wdata, input bit chk_lat);
      bit acc;
      @(posedge clk); #1;
      bus.req_we_i[port]                 = we;
      bus.req_addr_i[port*AB +: AB]      = addr;
      bus.req_wdata_i[port*BB +: BB]     = wdata;
      bus.req_valid_i[port]              = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         if (bus.req_ready_o[port]) acc = 1'b1;
      end
      if (!acc) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout port%0d addr %h: got no req_ready want accept", port, addr);
      end else begin
         push_exp(port, we, addr, wdata, chk_lat);
      end
      @(posedge clk); #1;
      bus.req_valid_i[port] = 1'b0;
   endtask

   task automatic wait_done();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL resp_timeout: got %0d outstanding want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic check_mem(input string name, input int idx, input bit we,
                            input logic [AB-1:0] addr, input logic [BB-1:0] wdata);
      n_cmp++;
      if (mem_log.size() <= idx) begin
         n_err++;
         $display("FAIL %s: got %0d mem transactions want >%0d", name, mem_log.size(), idx);
      end else if (mem_log[idx].we !== we || mem_log[idx].addr !== addr ||
                   (we && mem_log[idx].wdata !== wdata)) begin
         n_err++;
         $display("FAIL %s: got we=%b addr=%h want we=%b addr=%h", name,
                  mem_log[idx].we, mem_log[idx].addr, we, addr);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      n_cmp++;
      if (bus.req_ready_o !== '0 || bus.resp_valid_o !== '0 || bus.resp_addr_o !== '0 ||
          bus.resp_rdata_o !== '0 || bus.mem_req_o !== 1'b0 || bus.mem_we_o !== 1'b0 ||
          bus.mem_addr_o !== '0 || bus.mem_wdata_o !== '0) begin
         n_err++;
         $display("FAIL %s: got rdy=%b rv=%b mreq=%b maddr=%h want all zero", name,
                  bus.req_ready_o, bus.resp_valid_o, bus.mem_req_o, bus.mem_addr_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_outputs_zero("reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_read_fill_hit();
      mem_log.delete();
      do_req(0, 1'b0, 32'h0000_0040, '0, 1'b0);
      wait_done();
      n_cmp++;
      if (mem_log.size() !== 1) begin
         n_err++;
         $display("FAIL fill_count: got %0d want 1", mem_log.size());
      end
      check_mem("fill_0x40", 0, 1'b0, 32'h40, '0);
      mem_log.delete();
      mem_req_cycles = 0;
      do_req(0, 1'b0, 32'h0000_0040, '0, 1'b1);
      wait_done();
      n_cmp++;
      if (mem_req_cycles !== 0) begin
         n_err++;
         $display("FAIL read_hit_mem_idle: got %0d mem_req cycles want 0", mem_req_cycles);
      end
   endtask

   task automatic test_write_hit(output logic [BB-1:0] w);
      w = rand_block();
      mem_req_cycles = 0;
      do_req(1, 1'b1, 32'h0000_0040, w, 1'b1);
      do_req(1, 1'b0, 32'h0000_0040, '0, 1'b1);
      wait_done();
      n_cmp++;
      if (mem_req_cycles !== 0) begin
         n_err++;
         $display("FAIL write_hit_mem_idle: got %0d mem_req cycles want 0", mem_req_cycles);
      end
   endtask

   task automatic test_dirty_evict(input logic [BB-1:0] w);
      mem_log.delete();
      do_req(0, 1'b0, 32'h0000_0440, '0, 1'b0);
      wait_done();
      n_cmp++;
      if (mem_log.size() !== 2) begin
         n_err++;
         $display("FAIL evict_count: got %0d want 2", mem_log.size());
      end
      check_mem("writeback_0x40", 0, 1'b1, 32'h40, w);
      check_mem("fill_0x440", 1, 1'b0, 32'h440, '0);
   endtask

   task automatic test_back_to_back();
      logic [AB-1:0] a0 [4];
      logic [AB-1:0] a1 [4];
      int k0, k1, g;
      a0 = '{32'h440, 32'h440, 32'h100, 32'h100};
      a1 = '{32'h140, 32'h440, 32'h140, 32'h200};
      k0 = 0; k1 = 0;
      gnt_log.delete();
      @(posedge clk); #1;
      bus.req_we_i = '0;
      bus.req_addr_i[0 +: AB]  = a0[0];
      bus.req_addr_i[AB +: AB] = a1[0];
      bus.req_valid_i = 2'b11;
      for (int c = 0; c < 400 && (k0 < 4 || k1 < 4); c++) begin
         @(negedge clk);
         g = -1;
         if (bus.req_ready_o[0]) g = 0;
         else if (bus.req_ready_o[1]) g = 1;
         if (g == 0) begin push_exp(0, 1'b0, a0[k0], '0, 1'b0); k0++; end
         if (g == 1) begin push_exp(1, 1'b0, a1[k1], '0, 1'b0); k1++; end
         @(posedge clk); #1;
         if (g == 0) begin
            if (k0 < 4) bus.req_addr_i[0 +: AB] = a0[k0];
            else        bus.req_valid_i[0] = 1'b0;
         end
         if (g == 1) begin
            if (k1 < 4) bus.req_addr_i[AB +: AB] = a1[k1];
            else        bus.req_valid_i[1] = 1'b0;
         end
      end
      bus.req_valid_i = '0;
      wait_done();
      n_cmp++;
      if (gnt_log.size() !== 8) begin
         n_err++;
         $display("FAIL rr_grant_count: got %0d want 8", gnt_log.size());
      end
      // Port 0 was granted last before this test, so port 1 leads the rotation.
      for (int i = 0; i < gnt_log.size() && i < 8; i++) begin
         n_cmp++;
         if (gnt_log[i] !== (i + 1) % 2) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got port%0d want port%0d", i, gnt_log[i], (i + 1) % 2);
         end
      end
   endtask

   task automatic test_write_miss_alloc();
      mem_log.delete();
      do_req(0, 1'b1, 32'h0000_0080, rand_block(), 1'b1);
      do_req(1, 1'b0, 32'h0000_0080, '0, 1'b1);
      wait_done();
      n_cmp++;
      if (mem_log.size() !== 0) begin
         n_err++;
         $display("FAIL write_miss_no_fill: got %0d mem transactions want 0", mem_log.size());
      end
   endtask

   task automatic test_reset_mid_fill();
      bit seen;
      mem_en = 1'b0;
      do_req(0, 1'b0, 32'h0000_01C0, '0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.mem_req_o) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL fill_started: got mem_req_o=0 want 1");
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1 check_outputs_zero("reset_mid_fill");
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      mem_en = 1'b1;
      mem_log.delete();
      do_req(0, 1'b0, 32'h0000_01C0, '0, 1'b0);
      wait_done();
      check_mem("refill_after_reset", 0, 1'b0, 32'h1C0, '0);
      mem_log.delete();
      do_req(1, 1'b0, 32'h0000_0440, '0, 1'b0);
      wait_done();
      check_mem("cached_line_lost", 0, 1'b0, 32'h440, '0);
   endtask

   initial begin
      logic [BB-1:0] w;
      bus.req_valid_i = '0;
      bus.req_we_i    = '0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
      test_reset();
      test_read_fill_hit();
      test_write_hit(w);
      test_dirty_evict(w);
      test_back_to_back();
      test_write_miss_alloc();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no completion want $finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

endmodule
